// File: rtl/ysyx_040750_mem_arb_if.sv
// Request/response bundle between IF, LS, the memory arbiter and the shared memory bus.
// Handshakes: a requester raises *_req and holds it with its operands until rvalid/done.
// The bus address phase completes when O_bus_req is high and I_bus_ready is sampled high.
// The data phase completes when I_bus_done is sampled high, which may coincide with ready.
interface ysyx_040750_mem_arb_if #(
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              I_if_req;
  logic [31:0]       I_if_addr;
  logic              I_if_flush;
  logic              O_if_gnt;
  logic              O_if_rvalid;
  logic [31:0]       O_if_inst;
  logic              O_if_stall;

  logic              I_ls_req;
  logic              I_ls_wen;
  logic [31:0]       I_ls_addr;
  logic [DATA_W-1:0] I_ls_wdata;
  logic [MASK_W-1:0] I_ls_wmask;
  logic              O_ls_gnt;
  logic              O_ls_done;
  logic [DATA_W-1:0] O_ls_rdata;
  logic              O_ls_stall;

  logic              O_bus_req;
  logic              O_bus_wen;
  logic [31:0]       O_bus_addr;
  logic [DATA_W-1:0] O_bus_wdata;
  logic [MASK_W-1:0] O_bus_wmask;
  logic              I_bus_ready;
  logic              I_bus_done;
  logic [DATA_W-1:0] I_bus_rdata;

  modport master (
    input  I_if_req, I_if_addr, I_if_flush,
    output O_if_gnt, O_if_rvalid, O_if_inst, O_if_stall,
    input  I_ls_req, I_ls_wen, I_ls_addr, I_ls_wdata, I_ls_wmask,
    output O_ls_gnt, O_ls_done, O_ls_rdata, O_ls_stall,
    output O_bus_req, O_bus_wen, O_bus_addr, O_bus_wdata, O_bus_wmask,
    input  I_bus_ready, I_bus_done, I_bus_rdata
  );

  modport slave (
    output I_if_req, I_if_addr, I_if_flush,
    input  O_if_gnt, O_if_rvalid, O_if_inst, O_if_stall,
    output I_ls_req, I_ls_wen, I_ls_addr, I_ls_wdata, I_ls_wmask,
    input  O_ls_gnt, O_ls_done, O_ls_rdata, O_ls_stall,
    input  O_bus_req, O_bus_wen, O_bus_addr, O_bus_wdata, O_bus_wmask,
    output I_bus_ready, I_bus_done, I_bus_rdata
  );
endinterface

// File: rtl/ysyx_040750_mem_arb.sv
// Shares one memory bus port between instruction fetch and load/store.
// One transaction at a time: IDLE -> *_ADDR -> (*_DATA) -> IDLE, with rdata registered.
module ysyx_040750_mem_arb #(
  parameter int DATA_W = 64
) (
  input  logic                       I_sys_clk,
  input  logic                       I_rst_n,
  ysyx_040750_mem_arb_if.master      mem_if,
  output logic [2:0]                 O_dbg_state
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_ADDR = 3'd1,
    S_IF_DATA = 3'd2,
    S_LS_ADDR = 3'd3,
    S_LS_DATA = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              last_ls_q, last_ls_d;
  logic              drop_q, drop_d;
  logic [31:0]       addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              if_gnt_q, if_gnt_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_done_q, ls_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic              bus_req;
  logic              if_cmpl;
  logic              ls_cmpl;
  logic              ls_win;
  logic              in_if_txn;

  // LS normally wins; right after an LS completion a waiting fetch goes first.
  assign ls_win    = mem_if.I_ls_req & ~(last_ls_q & mem_if.I_if_req);
  assign in_if_txn = (state_q == S_IF_ADDR) || (state_q == S_IF_DATA);

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= S_IDLE;
      last_ls_q   <= 1'b0;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_done_q   <= 1'b0;
      if_inst_q   <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      drop_q      <= drop_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_done_q   <= ls_done_d;
      if_inst_q   <= if_inst_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    drop_d      = drop_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_done_d   = 1'b0;
    if_inst_d   = if_inst_q;
    ls_rdata_d  = ls_rdata_q;
    bus_req     = 1'b0;
    if_cmpl     = 1'b0;
    ls_cmpl     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ls_win) begin
          addr_d   = mem_if.I_ls_addr;
          wen_d    = mem_if.I_ls_wen;
          wdata_d  = mem_if.I_ls_wdata;
          wmask_d  = mem_if.I_ls_wen ? mem_if.I_ls_wmask : '0;
          ls_gnt_d = 1'b1;
          state_d  = S_LS_ADDR;
        end else if (mem_if.I_if_req) begin
          addr_d   = mem_if.I_if_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          if_gnt_d = 1'b1;
          state_d  = S_IF_ADDR;
        end
      end
      S_IF_ADDR: begin
        bus_req = 1'b1;
        if (mem_if.I_bus_ready) begin
          if (mem_if.I_bus_done) if_cmpl = 1'b1;
          else                   state_d = S_IF_DATA;
        end
      end
      S_IF_DATA: if_cmpl = mem_if.I_bus_done;
      S_LS_ADDR: begin
        bus_req = 1'b1;
        if (mem_if.I_bus_ready) begin
          if (mem_if.I_bus_done) ls_cmpl = 1'b1;
          else                   state_d = S_LS_DATA;
        end
      end
      S_LS_DATA: ls_cmpl = mem_if.I_bus_done;
      default:   state_d = S_IDLE;
    endcase

    // A cancelled fetch still runs to completion on the bus; only its result is discarded.
    if (in_if_txn && mem_if.I_if_flush) drop_d = 1'b1;

    if (if_cmpl) begin
      state_d     = S_IDLE;
      last_ls_d   = 1'b0;
      drop_d      = 1'b0;
      if_inst_d   = mem_if.I_bus_rdata[31:0];
      if_rvalid_d = ~drop_q & ~mem_if.I_if_flush;
    end

    if (ls_cmpl) begin
      state_d    = S_IDLE;
      last_ls_d  = 1'b1;
      ls_rdata_d = mem_if.I_bus_rdata;
      ls_done_d  = 1'b1;
    end
  end

  assign mem_if.O_bus_req   = bus_req;
  assign mem_if.O_bus_wen   = wen_q;
  assign mem_if.O_bus_addr  = addr_q;
  assign mem_if.O_bus_wdata = wdata_q;
  assign mem_if.O_bus_wmask = wmask_q;

  assign mem_if.O_if_gnt    = if_gnt_q;
  assign mem_if.O_if_rvalid = if_rvalid_q;
  assign mem_if.O_if_inst   = if_inst_q;
  assign mem_if.O_if_stall  = mem_if.I_if_req & ~if_rvalid_q;

  assign mem_if.O_ls_gnt    = ls_gnt_q;
  assign mem_if.O_ls_done   = ls_done_q;
  assign mem_if.O_ls_rdata  = ls_rdata_q;
  assign mem_if.O_ls_stall  = mem_if.I_ls_req & ~ls_done_q;

  assign O_dbg_state        = state_q;
endmodule
